// File: rtl/pid_ahb_master_if.sv
`default_nettype none
// ============================================================================
// Module      : pid_ahb_master_if
// Description : AHB-Lite bus bundle between the PID master and the PID slave
//               register port. The master modport drives address/control/
//               write data; the slave modport returns ready/response/read data.
// Revision    : 1.0 - initial release
// ============================================================================
interface pid_ahb_master_if;
   logic [31:0] m_ahb_haddr;
   logic [1:0]  m_ahb_htrans;
   logic        m_ahb_hwrite;
   logic [2:0]  m_ahb_hsize;
   logic [2:0]  m_ahb_hburst;
   logic [3:0]  m_ahb_hprot;
   logic        m_ahb_hmastlock;
   logic [31:0] m_ahb_hwdata;
   logic [31:0] m_ahb_hrdata;
   logic        m_ahb_hready;
   logic        m_ahb_hresp;

   modport master (
      output m_ahb_haddr, m_ahb_htrans, m_ahb_hwrite, m_ahb_hsize,
             m_ahb_hburst, m_ahb_hprot, m_ahb_hmastlock, m_ahb_hwdata,
      input  m_ahb_hrdata, m_ahb_hready, m_ahb_hresp
   );

   modport slave (
      input  m_ahb_haddr, m_ahb_htrans, m_ahb_hwrite, m_ahb_hsize,
             m_ahb_hburst, m_ahb_hprot, m_ahb_hmastlock, m_ahb_hwdata,
      output m_ahb_hrdata, m_ahb_hready, m_ahb_hresp
   );
endinterface
`default_nettype wire

// File: rtl/pid_ahb_master.sv
`default_nettype none
// ============================================================================
// Module      : pid_ahb_master
// Description : AHB-Lite single-write master for the PID accelerator. Runs
//               the INITN/COEFF initialisation list on cfg_start, then streams
//               accepted sample pairs into DIN0/DIN1. Non-pipelined: every
//               write is an address phase followed by a data phase.
// Revision    : 1.0 - initial release
// ============================================================================
module pid_ahb_master #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DW        = 25
) (
   input  logic                    HCLK,
   input  logic                    HRESETn,
   input  logic                    cfg_start,
   input  logic [DW-1:0]           cfg_coeff0,
   input  logic [DW-1:0]           cfg_coeff1,
   input  logic [DW-1:0]           cfg_coeff2,
   input  logic [DW-1:0]           cfg_coeff3,
   input  logic [DW-1:0]           cfg_coeff4,
   input  logic [DW-1:0]           cfg_coeff5,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [DW-1:0]           s_din0,
   input  logic [DW-1:0]           s_din1,
   pid_ahb_master_if.master        ahb,
   output logic                    busy,
   output logic                    init_done,
   output logic                    err,
   output logic [15:0]             sample_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INIT_ADDR = 3'd1,
      ST_INIT_DATA = 3'd2,
      ST_RUN       = 3'd3,
      ST_S_ADDR    = 3'd4,
      ST_S_DATA    = 3'd5,
      ST_ERR       = 3'd6
   } state_t;

   localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
   localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
   localparam logic [31:0] OFF_DIN0      = 32'h0000_001C;
   localparam logic [31:0] OFF_DIN1      = 32'h0000_0020;
   localparam logic [2:0]  IDX_LAST      = 3'd7;

   // INITN is written first and last; COEFF0..5 sit at 0x04..0x18
   function automatic logic [31:0] f_init_off(input logic [2:0] idx);
      f_init_off = (idx == IDX_LAST) ? 32'd0 : {27'd0, idx, 2'b00};
   endfunction

   state_t        r_state, w_state_nxt;
   logic [2:0]    r_idx, w_idx_nxt, w_idx_inc;
   logic          r_sidx, w_sidx_nxt;
   logic [31:0]   r_haddr, w_haddr_nxt;
   logic [1:0]    r_htrans, w_htrans_nxt;
   logic          r_hwrite, w_hwrite_nxt;
   logic [31:0]   r_hwdata, w_hwdata_nxt;
   logic          r_s_ready, r_busy, w_busy_nxt;
   logic          r_init_done, w_init_done_nxt;
   logic          r_err, w_err_nxt;
   logic [15:0]   r_sample_cnt, w_cnt_nxt;
   logic          w_start, w_accept;
   logic [DW-1:0] r_coeff [6];
   logic [DW-1:0] r_din0, r_din1;
   logic [DW-1:0] w_init_data;
   logic          w_unused_hrdata;

   assign w_idx_inc       = r_idx + 3'd1;
   assign w_unused_hrdata = ^ahb.m_ahb_hrdata;

   // Payload of the current init-list entry
   always_comb begin
      w_init_data = '0;
      case (r_idx)
         3'd1:    w_init_data = r_coeff[0];
         3'd2:    w_init_data = r_coeff[1];
         3'd3:    w_init_data = r_coeff[2];
         3'd4:    w_init_data = r_coeff[3];
         3'd5:    w_init_data = r_coeff[4];
         3'd6:    w_init_data = r_coeff[5];
         3'd7:    w_init_data = DW'(1);
         default: w_init_data = '0;
      endcase
   end

   // Next-state and next-value logic for every registered output
   always_comb begin
      w_state_nxt     = r_state;
      w_idx_nxt       = r_idx;
      w_sidx_nxt      = r_sidx;
      w_haddr_nxt     = r_haddr;
      w_htrans_nxt    = HTRANS_IDLE;
      w_hwrite_nxt    = 1'b0;
      w_hwdata_nxt    = r_hwdata;
      w_init_done_nxt = r_init_done;
      w_err_nxt       = r_err;
      w_cnt_nxt       = r_sample_cnt;
      w_start         = 1'b0;
      w_accept        = 1'b0;
      case (r_state)
         ST_IDLE: w_start = cfg_start;
         ST_ERR:  w_start = cfg_start;
         ST_RUN: begin
            // A restart request wins over a sample offered in the same cycle
            if (cfg_start) begin
               w_start = 1'b1;
            end else if (s_valid) begin
               w_accept     = 1'b1;
               w_state_nxt  = ST_S_ADDR;
               w_sidx_nxt   = 1'b0;
               w_haddr_nxt  = BASE_ADDR + OFF_DIN0;
               w_htrans_nxt = HTRANS_NONSEQ;
               w_hwrite_nxt = 1'b1;
            end
         end
         ST_INIT_ADDR, ST_S_ADDR: begin
            if (ahb.m_ahb_hready) begin
               w_state_nxt  = (r_state == ST_INIT_ADDR) ? ST_INIT_DATA : ST_S_DATA;
               w_hwdata_nxt = (r_state == ST_INIT_ADDR) ? 32'(w_init_data)
                            : (r_sidx ? 32'(r_din1) : 32'(r_din0));
            end else begin
               w_htrans_nxt = HTRANS_NONSEQ;
               w_hwrite_nxt = 1'b1;
            end
         end
         ST_INIT_DATA: begin
            if (ahb.m_ahb_hresp) begin
               w_state_nxt     = ST_ERR;
               w_err_nxt       = 1'b1;
               w_init_done_nxt = 1'b0;
            end else if (ahb.m_ahb_hready) begin
               if (r_idx == IDX_LAST) begin
                  w_state_nxt     = ST_RUN;
                  w_init_done_nxt = 1'b1;
               end else begin
                  w_state_nxt  = ST_INIT_ADDR;
                  w_idx_nxt    = w_idx_inc;
                  w_haddr_nxt  = BASE_ADDR + f_init_off(w_idx_inc);
                  w_htrans_nxt = HTRANS_NONSEQ;
                  w_hwrite_nxt = 1'b1;
               end
            end
         end
         ST_S_DATA: begin
            if (ahb.m_ahb_hresp) begin
               w_state_nxt     = ST_ERR;
               w_err_nxt       = 1'b1;
               w_init_done_nxt = 1'b0;
            end else if (ahb.m_ahb_hready) begin
               if (r_sidx) begin
                  w_state_nxt = ST_RUN;
                  w_cnt_nxt   = r_sample_cnt + 16'd1;
               end else begin
                  w_state_nxt  = ST_S_ADDR;
                  w_sidx_nxt   = 1'b1;
                  w_haddr_nxt  = BASE_ADDR + OFF_DIN1;
                  w_htrans_nxt = HTRANS_NONSEQ;
                  w_hwrite_nxt = 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_start) begin
         w_state_nxt     = ST_INIT_ADDR;
         w_idx_nxt       = 3'd0;
         w_haddr_nxt     = BASE_ADDR + f_init_off(3'd0);
         w_htrans_nxt    = HTRANS_NONSEQ;
         w_hwrite_nxt    = 1'b1;
         w_init_done_nxt = 1'b0;
         w_err_nxt       = 1'b0;
      end
      w_busy_nxt = (w_state_nxt == ST_INIT_ADDR) || (w_state_nxt == ST_INIT_DATA) ||
                   (w_state_nxt == ST_S_ADDR)    || (w_state_nxt == ST_S_DATA);
   end

   // State register and registered bus/status outputs
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state      <= ST_IDLE;
         r_idx        <= '0;
         r_sidx       <= 1'b0;
         r_haddr      <= '0;
         r_htrans     <= HTRANS_IDLE;
         r_hwrite     <= 1'b0;
         r_hwdata     <= '0;
         r_s_ready    <= 1'b0;
         r_busy       <= 1'b0;
         r_init_done  <= 1'b0;
         r_err        <= 1'b0;
         r_sample_cnt <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_idx        <= w_idx_nxt;
         r_sidx       <= w_sidx_nxt;
         r_haddr      <= w_haddr_nxt;
         r_htrans     <= w_htrans_nxt;
         r_hwrite     <= w_hwrite_nxt;
         r_hwdata     <= w_hwdata_nxt;
         r_s_ready    <= (w_state_nxt == ST_RUN);
         r_busy       <= w_busy_nxt;
         r_init_done  <= w_init_done_nxt;
         r_err        <= w_err_nxt;
         r_sample_cnt <= w_cnt_nxt;
      end
   end

   // Capture coefficients on an accepted start and samples on acceptance
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < 6; i++) r_coeff[i] <= '0;
         r_din0 <= '0;
         r_din1 <= '0;
      end else begin
         if (w_start) begin
            r_coeff[0] <= cfg_coeff0;
            r_coeff[1] <= cfg_coeff1;
            r_coeff[2] <= cfg_coeff2;
            r_coeff[3] <= cfg_coeff3;
            r_coeff[4] <= cfg_coeff4;
            r_coeff[5] <= cfg_coeff5;
         end
         if (w_accept) begin
            r_din0 <= s_din0;
            r_din1 <= s_din1;
         end
      end
   end

   assign ahb.m_ahb_haddr     = r_haddr;
   assign ahb.m_ahb_htrans    = r_htrans;
   assign ahb.m_ahb_hwrite    = r_hwrite;
   assign ahb.m_ahb_hsize     = 3'b010;
   assign ahb.m_ahb_hburst    = 3'b000;
   assign ahb.m_ahb_hprot     = 4'b0011;
   assign ahb.m_ahb_hmastlock = 1'b0;
   assign ahb.m_ahb_hwdata    = r_hwdata;
   assign s_ready             = r_s_ready;
   assign busy                = r_busy;
   assign init_done           = r_init_done;
   assign err                 = r_err;
   assign sample_cnt          = r_sample_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pid_ahb_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_pid_ahb_master
// Description : Self-checking bench for pid_ahb_master. A bus logger records
//               every completed OKAY write; a list-level model of the register
//               map supplies the expected write sequence and sample count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pid_ahb_master;
   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam int          DW   = 25;

   logic          HCLK = 1'b0;
   logic          HRESETn = 1'b0;
   logic          cfg_start = 1'b0;
   logic [DW-1:0] cf [6];
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_din0 = '0, s_din1 = '0;
   logic          s_ready, busy, init_done, err;
   logic [15:0]   sample_cnt;

   pid_ahb_master_if bus();

   pid_ahb_master #(.BASE_ADDR(BASE), .DW(DW)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .cfg_start(cfg_start),
      .cfg_coeff0(cf[0]), .cfg_coeff1(cf[1]), .cfg_coeff2(cf[2]),
      .cfg_coeff3(cf[3]), .cfg_coeff4(cf[4]), .cfg_coeff5(cf[5]),
      .s_valid(s_valid), .s_ready(s_ready), .s_din0(s_din0), .s_din1(s_din1),
      .ahb(bus), .busy(busy), .init_done(init_done), .err(err),
      .sample_cnt(sample_cnt)
   );

   always #5 HCLK = ~HCLK;

   int unsigned cyc = 0;
   always @(posedge HCLK) cyc <= cyc + 1;

   int n_assert = 0;
   int n_fail   = 0;

   // Bus logger: one entry per data phase that completes with OKAY
   logic [31:0] log_addr [$];
   logic [31:0] log_data [$];
   logic        pend = 1'b0;
   logic [31:0] pend_addr = '0;
   int          bad_ctrl = 0;
   always @(negedge HCLK) begin
      if (!HRESETn) begin
         pend = 1'b0;
      end else begin
         if (bus.m_ahb_htrans != 2'b00 &&
             (bus.m_ahb_htrans != 2'b10 || bus.m_ahb_hwrite !== 1'b1)) bad_ctrl++;
         if (pend) begin
            if (bus.m_ahb_hresp) pend = 1'b0;
            else if (bus.m_ahb_hready) begin
               log_addr.push_back(pend_addr);
               log_data.push_back(bus.m_ahb_hwdata);
               pend = 1'b0;
            end
         end else if (bus.m_ahb_htrans == 2'b10 && bus.m_ahb_hready) begin
            pend = 1'b1;
            pend_addr = bus.m_ahb_haddr;
         end
      end
   end

   // Reference model: expected write list and sample count
   logic [31:0] exp_addr [$];
   logic [31:0] exp_data [$];
   logic [15:0] exp_cnt = '0;

   task automatic model_init();
      exp_addr.push_back(BASE);  exp_data.push_back(32'd0);
      for (int i = 0; i < 6; i++) begin
         exp_addr.push_back(BASE + 32'(4 * (i + 1)));
         exp_data.push_back(32'(cf[i]));
      end
      exp_addr.push_back(BASE);  exp_data.push_back(32'd1);
   endtask

   task automatic model_pair(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      exp_addr.push_back(BASE + 32'h1C);  exp_data.push_back(32'(d0));
      exp_addr.push_back(BASE + 32'h20);  exp_data.push_back(32'(d1));
      exp_cnt = exp_cnt + 16'd1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_log(input string tag);
      int n;
      chk({tag, " write count"}, 32'(log_addr.size()), 32'(exp_addr.size()));
      n = (log_addr.size() < exp_addr.size()) ? log_addr.size() : exp_addr.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s haddr[%0d]", tag, i), log_addr[i], exp_addr[i]);
         chk($sformatf("%s hwdata[%0d]", tag, i), log_data[i], exp_data[i]);
      end
      log_addr.delete(); log_data.delete();
      exp_addr.delete(); exp_data.delete();
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic rand_coeffs();
      for (int i = 0; i < 6; i++) cf[i] = DW'($urandom);
   endtask

   task automatic pulse_start(output int unsigned t0);
      t0 = cyc;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
   endtask

   task automatic wait_init(input int unsigned t0, input int unsigned lat, input string tag);
      int n = 0;
      while (init_done !== 1'b1 && n < 100) begin tick(); n++; end
      chk({tag, " init latency"}, cyc - t0, lat);
      chk({tag, " s_ready in RUN"}, 32'(s_ready), 32'd1);
   endtask

   task automatic wait_addr(input logic [31:0] a);
      int n = 0;
      while (!(bus.m_ahb_htrans == 2'b10 && bus.m_ahb_haddr == a) && n < 60) begin
         tick(); n++;
      end
   endtask

   task automatic send_pairs(input int cnt, input bit fixed);
      int unsigned t_prev = 0;
      for (int k = 0; k < cnt; k++) begin
         logic [DW-1:0] d0, d1;
         int w;
         d0 = fixed ? 25'h1ABCDEF : DW'($urandom);
         d1 = fixed ? 25'h0000123 : DW'($urandom);
         s_din0 = d0; s_din1 = d1; s_valid = 1'b1;
         w = 0;
         while (s_ready !== 1'b1 && w < 50) begin tick(); w++; end
         tick();
         model_pair(d0, d1);
         chk("s_ready low after accept", 32'(s_ready), 32'd0);
         if (k > 0) chk("pair spacing", cyc - t_prev, 32'd5);
         t_prev = cyc;
      end
      s_valid = 1'b0;
      for (int w = 0; w < 50 && s_ready !== 1'b1; w++) tick();
   endtask

   initial begin
      int unsigned t0;
      bus.m_ahb_hready = 1'b1;
      bus.m_ahb_hresp  = 1'b0;
      bus.m_ahb_hrdata = '0;
      for (int i = 0; i < 6; i++) cf[i] = DW'(i + 1);

      // Reset values
      tick(); tick();
      chk("rst htrans", 32'(bus.m_ahb_htrans), 32'd0);
      chk("rst haddr", bus.m_ahb_haddr, 32'd0);
      chk("rst hwrite", 32'(bus.m_ahb_hwrite), 32'd0);
      chk("rst hwdata", bus.m_ahb_hwdata, 32'd0);
      chk("rst s_ready", 32'(s_ready), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst init_done", 32'(init_done), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      chk("rst sample_cnt", 32'(sample_cnt), 32'd0);
      HRESETn = 1'b1;
      tick(); tick();
      chk("idle no transfer", 32'(bus.m_ahb_htrans), 32'd0);

      // Zero-wait init with coefficients 1..6
      pulse_start(t0);
      chk("init busy", 32'(busy), 32'd1);
      wait_init(t0, 17, "init0");
      chk("init0 busy", 32'(busy), 32'd0);
      model_init();
      check_log("init0");

      // Back-to-back sample stream, fixed then random pairs
      send_pairs(3, 1'b1);
      chk("sample_cnt fixed", 32'(sample_cnt), 32'(exp_cnt));
      send_pairs(3, 1'b0);
      chk("sample_cnt rand", 32'(sample_cnt), 32'(exp_cnt));
      check_log("stream");

      // Wait states on COEFF3: 2 in address phase, 3 in data phase
      rand_coeffs();
      pulse_start(t0);
      wait_addr(BASE + 32'h10);
      bus.m_ahb_hready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("ws haddr held", bus.m_ahb_haddr, BASE + 32'h10);
         chk("ws htrans held", 32'(bus.m_ahb_htrans), 32'd2);
      end
      bus.m_ahb_hready = 1'b1;
      tick();
      bus.m_ahb_hready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ws hwdata held", bus.m_ahb_hwdata, 32'(cf[3]));
         chk("ws data htrans", 32'(bus.m_ahb_htrans), 32'd0);
      end
      bus.m_ahb_hready = 1'b1;
      wait_init(t0, 22, "waitst");
      model_init();
      check_log("waitst");

      // ERROR response on the COEFF2 data phase
      rand_coeffs();
      pulse_start(t0);
      wait_addr(BASE + 32'h0C);
      tick();
      bus.m_ahb_hresp  = 1'b1;
      bus.m_ahb_hready = 1'b0;
      tick();
      bus.m_ahb_hresp  = 1'b0;
      bus.m_ahb_hready = 1'b1;
      chk("error err", 32'(err), 32'd1);
      chk("error init_done", 32'(init_done), 32'd0);
      chk("error htrans", 32'(bus.m_ahb_htrans), 32'd0);
      chk("error busy", 32'(busy), 32'd0);
      s_valid = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk("error s_ready", 32'(s_ready), 32'd0);
      s_valid = 1'b0;
      chk("error sticky", 32'(err), 32'd1);
      model_init();
      for (int i = 0; i < 5; i++) begin void'(exp_addr.pop_back()); void'(exp_data.pop_back()); end
      check_log("error");
      rand_coeffs();
      pulse_start(t0);
      chk("recover err clear", 32'(err), 32'd0);
      wait_init(t0, 17, "recover");
      model_init();
      check_log("recover");

      // cfg_start and s_valid together in RUN: init wins
      rand_coeffs();
      s_din0 = DW'($urandom); s_din1 = DW'($urandom); s_valid = 1'b1;
      pulse_start(t0);
      s_valid = 1'b0;
      chk("prio haddr", bus.m_ahb_haddr, BASE);
      chk("prio init_done drop", 32'(init_done), 32'd0);
      wait_init(t0, 17, "prio");
      model_init();
      check_log("prio");
      chk("prio sample_cnt", 32'(sample_cnt), 32'(exp_cnt));

      // sample_cnt wrap
      force dut.r_sample_cnt = 16'hFFFE;
      #1;
      release dut.r_sample_cnt;
      exp_cnt = 16'hFFFE;
      send_pairs(2, 1'b0);
      chk("wrap to zero", 32'(sample_cnt), 32'd0);
      send_pairs(1, 1'b0);
      chk("after wrap", 32'(sample_cnt), 32'(exp_cnt));
      check_log("wrap");

      // Asynchronous reset during the DIN0 data phase
      s_din0 = DW'($urandom) | DW'(1); s_din1 = DW'($urandom); s_valid = 1'b1;
      for (int w = 0; w < 20 && s_ready !== 1'b1; w++) tick();
      tick();
      s_valid = 1'b0;
      tick();
      #2;
      HRESETn = 1'b0;
      #1;
      chk("arst htrans", 32'(bus.m_ahb_htrans), 32'd0);
      chk("arst haddr", bus.m_ahb_haddr, 32'd0);
      chk("arst hwdata", bus.m_ahb_hwdata, 32'd0);
      chk("arst hwrite", 32'(bus.m_ahb_hwrite), 32'd0);
      chk("arst busy", 32'(busy), 32'd0);
      chk("arst init_done", 32'(init_done), 32'd0);
      chk("arst sample_cnt", 32'(sample_cnt), 32'd0);
      exp_cnt = '0;
      tick();
      HRESETn = 1'b1;
      s_valid = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      s_valid = 1'b0;
      chk("post-rst s_ready", 32'(s_ready), 32'd0);
      chk("post-rst htrans", 32'(bus.m_ahb_htrans), 32'd0);
      check_log("post-rst");
      rand_coeffs();
      pulse_start(t0);
      wait_init(t0, 17, "reinit");
      model_init();
      check_log("reinit");

      // Fixed control signals and protocol legality
      chk("hsize", 32'(bus.m_ahb_hsize), 32'd2);
      chk("hburst", 32'(bus.m_ahb_hburst), 32'd0);
      chk("hprot", 32'(bus.m_ahb_hprot), 32'd3);
      chk("hmastlock", 32'(bus.m_ahb_hmastlock), 32'd0);
      chk("htrans/hwrite legality", 32'(bad_ctrl), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
